// File: rtl/octree_pkg.sv
// Octree layout parameters, FSM states and address helpers shared by the
// anchor reader and the anchor updater.
package octree_pkg;

  localparam int unsigned DATA_BUS_WIDTH     = 64;
  localparam int unsigned ADDR_BUS_WIDTH     = 64;
  localparam int unsigned FEATURE_LENTH      = 9;
  localparam int unsigned CHILDREN_NUM       = 8;
  localparam int unsigned LOG_CHILD_NUM      = 3;
  localparam int unsigned TREE_LEVEL         = 5;
  localparam int unsigned LOG_TREE_LEVEL     = 3;
  localparam int unsigned TREE_ADDR_START    = 0;
  localparam int unsigned FEATURE_START_ADDR = 1200;
  localparam int unsigned ENCODE_ADDR_WIDTH  = LOG_CHILD_NUM * TREE_LEVEL + LOG_TREE_LEVEL;
  localparam int unsigned NODE_W             = 32;
  localparam int unsigned IDX_W              = 4;

  typedef logic [NODE_W-1:0]         node_t;
  typedef logic [ADDR_BUS_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TREE_RD,
    ST_CHECK,
    ST_FEAT_RD,
    ST_FEAT_TAIL,
    ST_DONE
  } state_t;

  // Depth 0 is the most significant path field, just below the level field.
  function automatic logic [LOG_CHILD_NUM-1:0] path_field(
    input logic [ENCODE_ADDR_WIDTH-1:0] pos,
    input logic [LOG_TREE_LEVEL-1:0]    d
  );
    logic [ENCODE_ADDR_WIDTH-1:0] sh;
    sh = pos >> (LOG_CHILD_NUM * (TREE_LEVEL - 1 - 32'(d)));
    return sh[LOG_CHILD_NUM-1:0];
  endfunction

  function automatic node_t child_node(input node_t n, input logic [LOG_CHILD_NUM-1:0] c);
    return n * NODE_W'(CHILDREN_NUM) + NODE_W'(c) + NODE_W'(1);
  endfunction

  function automatic addr_t node_addr(input node_t n);
    return ADDR_BUS_WIDTH'(TREE_ADDR_START) + ADDR_BUS_WIDTH'(n);
  endfunction

  function automatic addr_t feat_addr(input node_t n, input logic [IDX_W-1:0] k);
    return ADDR_BUS_WIDTH'(FEATURE_START_ADDR)
         + ADDR_BUS_WIDTH'(n) * ADDR_BUS_WIDTH'(FEATURE_LENTH)
         + ADDR_BUS_WIDTH'(k);
  endfunction

endpackage

// File: rtl/octree_addr_gen.sv
// Combinational node-word and feature-word address generation for the
// octree SRAM layout.
module octree_addr_gen
  import octree_pkg::*;
(
  input  node_t            node,
  input  logic [IDX_W-1:0] k,
  output addr_t            node_addr_c,
  output addr_t            feat_addr_c
);

  assign node_addr_c = node_addr(node);
  assign feat_addr_c = feat_addr(node, k);

endmodule

// File: rtl/octree_anchor_reader.sv
// Walks the octree for an encoded anchor position and streams the anchor's
// feature words on a hit, or reports not-found on a miss.
module octree_anchor_reader
  import octree_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         query_req,
  input  logic [ENCODE_ADDR_WIDTH-1:0] pos_encode,
  output logic                         query_busy,
  output logic                         query_done,
  output logic                         query_hit,
  output logic                         feature_valid,
  output logic [IDX_W-1:0]             feature_idx,
  output logic [DATA_BUS_WIDTH-1:0]    feature_out,
  output logic                         mem_sram_CEN,
  output logic [ADDR_BUS_WIDTH-1:0]    mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0]    mem_sram_D,
  output logic                         mem_sram_GWEN,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_sram_Q
);

  state_t                       state;
  logic [ENCODE_ADDR_WIDTH-1:0] pos;
  logic [LOG_TREE_LEVEL-1:0]    depth;
  node_t                        parent;
  logic [IDX_W-1:0]             k;

  logic [LOG_TREE_LEVEL-1:0]    level;
  logic [LOG_CHILD_NUM-1:0]     field;
  logic [CHILDREN_NUM-1:0]      mask;
  node_t                        next_node;
  node_t                        sel_node;
  logic [IDX_W-1:0]             sel_k;
  addr_t                        node_a;
  addr_t                        feat_a;

  assign mem_sram_D    = '0;
  assign mem_sram_GWEN = 1'b1;
  // Feature words come straight from the SRAM read port in the cycle after issue.
  assign feature_out   = feature_valid ? mem_sram_Q : '0;

  assign level = pos[ENCODE_ADDR_WIDTH-1 -: LOG_TREE_LEVEL];

  // Pick the node/word whose address is registered onto the SRAM bus next.
  always_comb begin
    field     = path_field(pos, depth);
    mask      = mem_sram_Q[CHILDREN_NUM-1:0];
    next_node = child_node(parent, field);
    sel_node  = parent;
    sel_k     = k + IDX_W'(1);
    case (state)
      ST_IDLE: begin
        sel_node = '0;
        sel_k    = '0;
      end
      ST_CHECK: begin
        sel_node = next_node;
        sel_k    = '0;
      end
      default: ;
    endcase
  end

  octree_addr_gen u_addr_gen (
    .node        (sel_node),
    .k           (sel_k),
    .node_addr_c (node_a),
    .feat_addr_c (feat_a)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pos           <= '0;
      depth         <= '0;
      parent        <= '0;
      k             <= '0;
      query_busy    <= 1'b0;
      query_done    <= 1'b0;
      query_hit     <= 1'b0;
      feature_valid <= 1'b0;
      feature_idx   <= '0;
      mem_sram_CEN  <= 1'b1;
      mem_sram_A    <= '0;
    end else begin
      mem_sram_CEN  <= 1'b1;
      feature_valid <= 1'b0;
      query_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (query_req) begin
            pos        <= pos_encode;
            parent     <= '0;
            depth      <= '0;
            k          <= '0;
            query_busy <= 1'b1;
            query_hit  <= 1'b0;
            if (pos_encode[ENCODE_ADDR_WIDTH-1 -: LOG_TREE_LEVEL] >= LOG_TREE_LEVEL'(TREE_LEVEL)) begin
              state <= ST_DONE;
            end else begin
              state        <= ST_TREE_RD;
              mem_sram_CEN <= 1'b0;
              mem_sram_A   <= node_a;
            end
          end
        end
        ST_TREE_RD: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!mask[field]) begin
            state      <= ST_DONE;
            query_done <= 1'b1;
            query_busy <= 1'b0;
            query_hit  <= 1'b0;
          end else begin
            parent       <= next_node;
            mem_sram_CEN <= 1'b0;
            if (depth == level) begin
              state      <= ST_FEAT_RD;
              k          <= '0;
              mem_sram_A <= feat_a;
            end else begin
              state      <= ST_TREE_RD;
              depth      <= depth + LOG_TREE_LEVEL'(1);
              mem_sram_A <= node_a;
            end
          end
        end
        ST_FEAT_RD: begin
          feature_valid <= 1'b1;
          feature_idx   <= k;
          if (k == IDX_W'(FEATURE_LENTH - 1)) begin
            state <= ST_FEAT_TAIL;
          end else begin
            k            <= k + IDX_W'(1);
            mem_sram_CEN <= 1'b0;
            mem_sram_A   <= feat_a;
          end
        end
        ST_FEAT_TAIL: begin
          state      <= ST_DONE;
          query_done <= 1'b1;
          query_busy <= 1'b0;
          query_hit  <= 1'b1;
        end
        ST_DONE: begin
          // An out-of-range level arrives here with no pulse yet; emit it now.
          if (query_done) begin
            state     <= ST_IDLE;
            query_hit <= 1'b0;
          end else begin
            query_done <= 1'b1;
            query_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/octree_anchor_reader.md
Name: octree_anchor_reader

Overview:
- Read-side counterpart of the anchor updater.
- Takes an encoded anchor position and walks the octree stored in the shared single-port SRAM, checking the child-valid mask at each depth.
- On a hit, streams the anchor's FEATURE_LENTH feature words out. On a miss, reports not-found.
- Sits beside the updater on the SRAM interface; an external arbiter grants one of them at a time.

Parameters:
- DATA_BUS_WIDTH, 64, SRAM data width and feature word width
- ADDR_BUS_WIDTH, 64, SRAM address width
- FEATURE_LENTH, 9, feature words per anchor
- CHILDREN_NUM, 8, children per node; the valid mask is Q[CHILDREN_NUM-1:0]
- LOG_CHILD_NUM, 3, bits per path field
- TREE_LEVEL, 5, number of path fields
- LOG_TREE_LEVEL, 3, width of the level field
- TREE_ADDR_START, 0, base word address of node words
- FEATURE_START_ADDR, 1200, base word address of feature blocks
- ENCODE_ADDR_WIDTH, LOG_CHILD_NUM*TREE_LEVEL+LOG_TREE_LEVEL, pos_encode width

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- query_req  in  1  start pulse; sampled only in IDLE
- pos_encode  in  ENCODE_ADDR_WIDTH  [17:15] = level L; field for depth d = bits [14-3d:12-3d]
- query_busy  out  1  high from the cycle after acceptance until done
- query_done  out  1  one-cycle completion pulse
- query_hit  out  1  valid while query_done is high; 1 = anchor present
- feature_valid  out  1  feature_out holds a valid word this cycle
- feature_idx  out  4  word index 0..FEATURE_LENTH-1
- feature_out  out  DATA_BUS_WIDTH  feature word
- mem_sram_CEN  out  1  active-low chip enable
- mem_sram_A  out  ADDR_BUS_WIDTH  word address
- mem_sram_D  out  DATA_BUS_WIDTH  always 0
- mem_sram_GWEN  out  1  tied high; this block never writes
- mem_sram_Q  in  DATA_BUS_WIDTH  read data, valid the cycle after CEN=0

Behaviour:
- Reset: all outputs 0 except mem_sram_CEN=1 and mem_sram_GWEN=1; FSM goes to IDLE. A reset mid-query aborts it with no done pulse.
- Addressing:
  - Root node index is 0.
  - child(n,c) = n*CHILDREN_NUM + c + 1.
  - Node word address = TREE_ADDR_START + n.
  - Feature word k address = FEATURE_START_ADDR + n*FEATURE_LENTH + k.
  - Arithmetic is unsigned and zero-extended to ADDR_BUS_WIDTH.
- FSM states: IDLE -> TREE_RD -> CHECK -> (TREE_RD | FEAT_RD | DONE); FEAT_RD -> FEAT_TAIL -> DONE -> IDLE.
- IDLE: when query_req=1, latch pos_encode, set parent=0 and d=0. If L >= TREE_LEVEL, go to DONE with hit=0 and make no SRAM access.
- TREE_RD: CEN=0, A = node address of parent.
- CHECK: let c = path field d.
  - If Q[c]=0: miss, go to DONE.
  - Else parent <= child(parent,c).
  - If d==L go to FEAT_RD; otherwise d++ and go to TREE_RD.
- FEAT_RD: issue FEATURE_LENTH reads back-to-back, k=0..8, one per cycle.
- Feature output: feature_valid=1 with feature_out=Q and feature_idx=k one cycle after each issue. The last word is presented in FEAT_TAIL.
- DONE: query_done=1 for one cycle, query_hit=result, query_busy=0; return to IDLE.
- Timing (cycle 0 = req sampled):
  - Depth-d read is issued at cycle 1+2d.
  - Miss at depth d: done at cycle 3+2d.
  - Hit: features valid in cycles 4+2L .. 12+2L; done at cycle 13+2L.
- query_req while busy or in DONE is ignored; no queueing.
- CEN is high in every cycle with no read issued. No backpressure on the feature stream.

Decomposition:
- Shared package octree_pkg holds:
  - the tree and SRAM-layout parameters shared with the updater;
  - the FSM state enum;
  - functions path_field(pos,d), child_node(n,c), node_addr(n) and feat_addr(n,k).
- One sub-module, octree_addr_gen: combinational node/feature address generation. The updater reuses it.

Test Plan:
- All-zero SRAM, pos_encode={3'd2,3'd0,3'd0,3'd3,3'd1,3'd0} -> one read at addr 0 in cycle 1; done in cycle 3 with hit=0; no feature_valid.
- Preload addr0 bit0, addr1 bit0, addr9 bit3, and words 1884..1892 = 10..18; same query -> reads at 0, 1, 9 in cycles 1, 3, 5; features 10..18 with idx 0..8 in cycles 8..16; done in cycle 17 with hit=1.
- Same preload with addr9 bit3 cleared -> miss at depth 2; done in cycle 7 with hit=0.
- Level field 3'd5 (>= TREE_LEVEL) -> done in cycle 2 with hit=0; CEN stays 1 throughout.
- During the hit query, assert query_req at cycles 5 and 17 -> both ignored, with a single done pulse. Also assert rst at cycle 10 -> all outputs return to reset values from cycle 11 and no done pulse occurs.
- Throughout all scenarios, GWEN must never be 0.
